ddr3_cmd_scheduler: RTL
=======================

Name: ddr3_cmd_scheduler

Overview:
- Sits after the DDR3 init sequencer finishes (init_done) and owns the DDR3 command bus from then on.
- Accepts single-beat read/write requests on a valid/ready port and issues the sequence ACT -> RD/WR -> PRE under a closed-page policy.
- Generates periodic auto-refresh (REF) from a tREFI timer and arbitrates refresh against user requests.
- Drives cmd/ba/addr, which the top level muxes onto RAS_N/CAS_N/WE_N, BA and ADDR after init.

Parameters:
- T_RCD, 6: cycles from ACT to RD/WR.
- T_RAS, 15: minimum cycles from ACT to PRE.
- T_WR2PRE, 16: minimum cycles from WR to PRE (CWL + BL/2 + tWR).
- T_RD2PRE, 4: minimum cycles from RD to PRE (tRTP).
- T_RP, 6: cycles from PRE to the next ACT or REF.
- T_RFC, 88: cycles from REF to the next ACT or REF.
- T_REFI, 3120: refresh interval, in cycles.
- MAX_POSTPONE, 8: number of pending refreshes at which a refresh is forced ahead of user traffic.

Ports:
- clk, in, 1: controller clock; all logic is on the rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- init_done, in, 1: init sequence complete; sampled only in WAIT_INIT.
- req_valid, in, 1: request present.
- req_ready, out, 1: request accepted on a cycle where valid && ready.
- req_we, in, 1: 1 = write, 0 = read.
- req_bank, in, 3: bank address.
- req_row, in, 13: row address.
- req_col, in, 10: column address.
- cmd, out, 3: {RAS_N,CAS_N,WE_N}. Encoding: MRS=000, REF=001, PRE=010, ACT=011, WR=100, RD=101, ZQC=110, NOP=111.
- ba, out, 3: bank for the current command.
- addr, out, 13: address for the current command.
- rd_issued, out, 1: one-cycle pulse, coincident with RD on cmd.
- wr_issued, out, 1: one-cycle pulse, coincident with WR on cmd.
- ref_busy, out, 1: high from the REF cycle through the end of tRFC.
- ref_overflow, out, 1: sticky error flag.

Behaviour:
- Reset (async, rst_n=0): all outputs take their reset values immediately.
  - cmd=NOP, ba=0, addr=0, req_ready=0, rd_issued=0, wr_issued=0, ref_busy=0, ref_overflow=0.
  - State -> WAIT_INIT; refresh pending count=0; all timers=0.
  - Reset asserted mid-sequence abandons the sequence; no PRE is issued.
- All outputs are registered. cmd is NOP in every cycle except a single-cycle command.
- States: WAIT_INIT, IDLE, RCD_WAIT, PRE_WAIT, RP_WAIT, RFC_WAIT.
- WAIT_INIT:
  - Stays here until init_done=1. No refresh ticks occur.
  - On exit, the tREFI timer is loaded with T_REFI and the state goes to IDLE.
- Refresh timer:
  - Decrements in every state except WAIT_INIT.
  - On expiry: pending += 1 and the timer is reloaded with T_REFI.
  - Pending saturates at MAX_POSTPONE. A tick arriving while pending==MAX_POSTPONE sets ref_overflow.
  - A tick in the same cycle as a REF issue leaves pending unchanged.
- IDLE arbitration, evaluated each cycle:
  - Refresh is chosen if pending!=0 && (!req_valid || pending>=MAX_POSTPONE).
  - Otherwise req_ready=1.
  - req_ready is combinational from state and pending only; it never depends on req_valid.
- Refresh chosen:
  - Next cycle: cmd=REF, ba=0, addr=0, pending -= 1, ref_busy=1.
  - Go to RFC_WAIT.
  - After T_RFC cycles from REF: return to IDLE and drop ref_busy.
- Request accepted:
  - bank, row, col and we are captured.
  - Next cycle: cmd=ACT, ba=bank, addr=row. Go to RCD_WAIT.
  - The tRAS timer starts at the ACT cycle.
- RCD_WAIT:
  - T_RCD cycles after ACT: cmd=WR or RD.
  - ba=bank; addr={2'b00, 1'b0 (no auto-precharge), col}.
  - The matching rd_issued/wr_issued pulse fires in the same cycle.
  - Go to PRE_WAIT.
- PRE_WAIT:
  - Issues cmd=PRE with ba=bank and addr=0 (A10=0, single bank).
  - PRE is issued on the first cycle satisfying both: at least T_RAS since ACT, and at least T_WR2PRE (write) or T_RD2PRE (read) since the column command.
  - Go to RP_WAIT.
- RP_WAIT: T_RP cycles after PRE, return to IDLE. req_ready can assert in that same cycle.
- Timing semantics: "N cycles after" means the next command lands exactly N clk cycles after the previous one, never earlier.
- Only one request is in flight at a time. All banks are closed in IDLE, so REF is always legal there.
- req_* fields are ignored unless valid && ready.

Test Plan:
- Reset, then init_done=1 at cycle 0; single write (bank 2, row 0x155, col 0x3A) accepted at edge A -> ACT(ba=2, addr=0x155) at A+1; WR(addr=0x03A) with wr_issued at A+7; PRE(ba=2) at A+23; req_ready high at A+29.
- Single read accepted at edge A -> ACT at A+1; RD with rd_issued at A+7; PRE at A+16 (bound by tRAS); req_ready at A+22.
- No traffic -> first REF exactly T_REFI+1 cycles after leaving WAIT_INIT; ref_busy high for 88 cycles; no other non-NOP commands appear.
- T_REFI=100, req_valid held high with back-to-back reads -> REF is deferred until pending reaches 8; exactly one forced REF; user reads then resume while pending=7; ref_overflow stays 0.
- T_REFI=10, T_RFC=88, no traffic -> pending saturates and ref_overflow sets and remains set.
- rst_n pulsed low between ACT and RD -> cmd=NOP and req_ready=0 immediately; no RD/PRE issued; waits in WAIT_INIT for init_done.

Source files
------------

// File: rtl/ddr3_cmd_scheduler_if.sv
// Request handshake and DDR3 command bus between a requester and ddr3_cmd_scheduler.
interface ddr3_cmd_scheduler_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_bank;
   logic [12:0] req_row;
   logic [9:0]  req_col;
   logic [2:0]  cmd;
   logic [2:0]  ba;
   logic [12:0] addr;
   logic        rd_issued;
   logic        wr_issued;

   modport master (
      output req_valid, req_we, req_bank, req_row, req_col,
      input  req_ready, cmd, ba, addr, rd_issued, wr_issued
   );

   modport slave (
      input  req_valid, req_we, req_bank, req_row, req_col,
      output req_ready, cmd, ba, addr, rd_issued, wr_issued
   );
endinterface

// File: rtl/ddr3_cmd_scheduler.sv
// Closed-page DDR3 command scheduler: ACT -> RD/WR -> PRE per request, with
// tREFI-driven auto-refresh that is postponed behind traffic up to MAX_POSTPONE.
module ddr3_cmd_scheduler #(
   parameter int unsigned T_RCD        = 6,
   parameter int unsigned T_RAS        = 15,
   parameter int unsigned T_WR2PRE     = 16,
   parameter int unsigned T_RD2PRE     = 4,
   parameter int unsigned T_RP         = 6,
   parameter int unsigned T_RFC        = 88,
   parameter int unsigned T_REFI       = 3120,
   parameter int unsigned MAX_POSTPONE = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 init_done,
   ddr3_cmd_scheduler_if.slave  bus,
   output logic                 ref_busy,
   output logic                 ref_overflow
);

   typedef enum logic [2:0] {
      S_WAIT_INIT, S_IDLE, S_RCD_WAIT, S_PRE_WAIT, S_RP_WAIT, S_RFC_WAIT
   } state_e;

   typedef enum logic [2:0] {
      CMD_MRS = 3'b000, CMD_REF = 3'b001, CMD_PRE = 3'b010, CMD_ACT = 3'b011,
      CMD_WR  = 3'b100, CMD_RD  = 3'b101, CMD_ZQC = 3'b110, CMD_NOP = 3'b111
   } cmd_e;

   localparam int unsigned TW = $clog2(T_RCD + T_RAS + T_WR2PRE + T_RD2PRE + T_RP + T_RFC + 1);
   localparam int unsigned RW = $clog2(T_REFI + 1);
   localparam int unsigned PW = $clog2(MAX_POSTPONE + 1);

   // Timers are loaded with N-1 so the next command lands exactly N cycles later.
   localparam logic [TW-1:0] RCD_LD    = TW'(T_RCD - 1);
   localparam logic [TW-1:0] RAS_LD    = TW'(T_RAS - 1);
   localparam logic [TW-1:0] WR2PRE_LD = TW'(T_WR2PRE - 1);
   localparam logic [TW-1:0] RD2PRE_LD = TW'(T_RD2PRE - 1);
   localparam logic [TW-1:0] RP_LD     = TW'(T_RP - 1);
   localparam logic [TW-1:0] RFC_LD    = TW'(T_RFC - 1);
   localparam logic [RW-1:0] REFI_LD   = RW'(T_REFI);
   localparam logic [PW-1:0] MAXP      = PW'(MAX_POSTPONE);

   state_e        state_q, state_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [TW-1:0] ras_q, ras_d;
   logic [RW-1:0] refi_q, refi_d;
   logic [PW-1:0] pend_q, pend_d;
   logic [2:0]    bank_q, bank_d;
   logic [9:0]    col_q, col_d;
   logic          we_q, we_d;
   cmd_e          cmd_q, cmd_d;
   logic [2:0]    ba_q, ba_d;
   logic [12:0]   addr_q, addr_d;
   logic          rd_q, rd_d, wr_q, wr_d;
   logic          busy_q, busy_d;
   logic          ovf_q, ovf_d;
   logic          ready, tick, ref_go;

   assign ready = (state_q == S_IDLE) && (pend_q < MAXP);

   always_comb begin
      state_d = state_q;
      tmr_d   = (tmr_q != '0) ? tmr_q - 1'b1 : '0;
      ras_d   = (ras_q != '0) ? ras_q - 1'b1 : '0;
      refi_d  = refi_q;
      pend_d  = pend_q;
      bank_d  = bank_q;
      col_d   = col_q;
      we_d    = we_q;
      cmd_d   = CMD_NOP;
      ba_d    = '0;
      addr_d  = '0;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      busy_d  = busy_q;
      ovf_d   = ovf_q;
      tick    = 1'b0;
      ref_go  = 1'b0;

      if (state_q != S_WAIT_INIT) begin
         if (refi_q == RW'(1)) begin
            tick   = 1'b1;
            refi_d = REFI_LD;
         end else begin
            refi_d = refi_q - 1'b1;
         end
      end

      case (state_q)
         S_WAIT_INIT: begin
            if (init_done) begin
               state_d = S_IDLE;
               refi_d  = REFI_LD;
            end
         end
         S_IDLE: begin
            // A ready request wins; ready already drops once refresh must be forced.
            if (bus.req_valid && ready) begin
               bank_d  = bus.req_bank;
               col_d   = bus.req_col;
               we_d    = bus.req_we;
               cmd_d   = CMD_ACT;
               ba_d    = bus.req_bank;
               addr_d  = bus.req_row;
               tmr_d   = RCD_LD;
               ras_d   = RAS_LD;
               state_d = S_RCD_WAIT;
            end else if (pend_q != '0) begin
               ref_go  = 1'b1;
               cmd_d   = CMD_REF;
               busy_d  = 1'b1;
               tmr_d   = RFC_LD;
               state_d = S_RFC_WAIT;
            end
         end
         S_RCD_WAIT: begin
            if (tmr_q == '0) begin
               cmd_d   = we_q ? CMD_WR : CMD_RD;
               ba_d    = bank_q;
               addr_d  = {3'b000, col_q};
               wr_d    = we_q;
               rd_d    = !we_q;
               tmr_d   = we_q ? WR2PRE_LD : RD2PRE_LD;
               state_d = S_PRE_WAIT;
            end
         end
         S_PRE_WAIT: begin
            if ((tmr_q == '0) && (ras_q == '0)) begin
               cmd_d   = CMD_PRE;
               ba_d    = bank_q;
               tmr_d   = RP_LD;
               state_d = S_RP_WAIT;
            end
         end
         S_RP_WAIT: begin
            if (tmr_q == '0) state_d = S_IDLE;
         end
         S_RFC_WAIT: begin
            if (tmr_q == '0) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_WAIT_INIT;
      endcase

      if (tick && !ref_go) begin
         if (pend_q == MAXP) ovf_d = 1'b1;
         else                pend_d = pend_q + 1'b1;
      end else if (!tick && ref_go) begin
         pend_d = pend_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_WAIT_INIT;
         tmr_q   <= '0;
         ras_q   <= '0;
         refi_q  <= '0;
         pend_q  <= '0;
         bank_q  <= '0;
         col_q   <= '0;
         we_q    <= 1'b0;
         cmd_q   <= CMD_NOP;
         ba_q    <= '0;
         addr_q  <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         ras_q   <= ras_d;
         refi_q  <= refi_d;
         pend_q  <= pend_d;
         bank_q  <= bank_d;
         col_q   <= col_d;
         we_q    <= we_d;
         cmd_q   <= cmd_d;
         ba_q    <= ba_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         busy_q  <= busy_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.req_ready = ready;
   assign bus.cmd       = cmd_q;
   assign bus.ba        = ba_q;
   assign bus.addr      = addr_q;
   assign bus.rd_issued = rd_q;
   assign bus.wr_issued = wr_q;
   assign ref_busy      = busy_q;
   assign ref_overflow  = ovf_q;

endmodule
